// File: rtl/instruction_fetcher_pkg.sv
// Shared fetch/decode definitions: opcode constants, datapath defaults and fetch FSM states.
package instruction_fetcher_pkg;

    localparam int          XLEN_DEF     = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

    // True for any opcode that can redirect control flow.
    function automatic logic is_ctrl_flow(input logic [6:0] opc);
        return (opc == OPC_JAL) || (opc == OPC_JALR) || (opc == OPC_BRANCH);
    endfunction

endpackage

// File: rtl/instruction_fetcher_if.sv
// Fetch-side bus: icache request/response plus the decoder delivery port.
interface instruction_fetcher_if #(
    parameter int XLEN = 32
);
    logic            icache_req;
    logic [XLEN-1:0] icache_addr;
    logic            icache_valid;
    logic [XLEN-1:0] icache_inst;
    logic            to_dec;
    logic [XLEN-1:0] to_dec_pc;
    logic [XLEN-1:0] to_dec_inst;
    logic [XLEN-1:0] to_dec_pred_pc;

    modport master (
        output icache_req, icache_addr,
        input  icache_valid, icache_inst,
        output to_dec, to_dec_pc, to_dec_inst, to_dec_pred_pc
    );

    modport slave (
        input  icache_req, icache_addr,
        output icache_valid, icache_inst,
        input  to_dec, to_dec_pc, to_dec_inst, to_dec_pred_pc
    );
endinterface

// File: rtl/instruction_fetcher_next_pc_gen.sv
// Static next-PC predictor: JAL targets are taken, every other word falls through to pc+4.
module instruction_fetcher_next_pc_gen
    import instruction_fetcher_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] inst_i,
    output logic [XLEN-1:0] next_pc_o
);

    logic [XLEN-1:0] j_imm;
    logic            unused_rd;

    // J-immediate, sign bit replicated up to XLEN.
    assign j_imm     = {{(XLEN-20){inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
    assign unused_rd = ^inst_i[11:7];
    assign next_pc_o = pc_i + ((inst_i[6:0] == OPC_JAL) ? j_imm : XLEN'(4));

endmodule

// File: rtl/instruction_fetcher.sv
// Instruction fetch front end: one outstanding icache request, registered decoder delivery.
//   state   | meaning
//   ST_REQ  | idle, issue a request at pc once the back end is not stalled
//   ST_WAIT | request outstanding, waiting for the icache response pulse
//   ST_HOLD | word captured under stall, deliver when stall releases
module instruction_fetcher
    import instruction_fetcher_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  clear,
    input  logic [XLEN-1:0]       clear_pc,
    input  logic                  stall,
    instruction_fetcher_if.master fetch_if
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            req_q, req_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic            to_dec_q, to_dec_d;
    logic [XLEN-1:0] dec_pc_q, dec_pc_d;
    logic [XLEN-1:0] dec_inst_q, dec_inst_d;
    logic [XLEN-1:0] pred_q, pred_d;
    logic [XLEN-1:0] next_pc;

    instruction_fetcher_next_pc_gen #(.XLEN(XLEN)) u_next_pc (
        .pc_i      (pc_q),
        .inst_i    (fetch_if.icache_inst),
        .next_pc_o (next_pc)
    );

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= ST_REQ;
            pc_q       <= RESET_PC;
            req_q      <= 1'b0;
            addr_q     <= '0;
            to_dec_q   <= 1'b0;
            dec_pc_q   <= '0;
            dec_inst_q <= '0;
            pred_q     <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            to_dec_q   <= to_dec_d;
            dec_pc_q   <= dec_pc_d;
            dec_inst_q <= dec_inst_d;
            pred_q     <= pred_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_d      = req_q;
        addr_d     = addr_q;
        to_dec_d   = to_dec_q;
        dec_pc_d   = dec_pc_q;
        dec_inst_d = dec_inst_q;
        pred_d     = pred_q;
        if (rdy_in) begin
            to_dec_d = 1'b0;
            // A flush wins over everything, including a response arriving this cycle.
            if (clear) begin
                pc_d    = {clear_pc[XLEN-1:2], 2'b00};
                req_d   = 1'b0;
                state_d = ST_REQ;
            end else begin
                case (state_q)
                    ST_REQ: begin
                        if (!stall) begin
                            req_d   = 1'b1;
                            addr_d  = {pc_q[XLEN-1:2], 2'b00};
                            state_d = ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (fetch_if.icache_valid) begin
                            req_d      = 1'b0;
                            dec_pc_d   = pc_q;
                            dec_inst_d = fetch_if.icache_inst;
                            pred_d     = next_pc;
                            pc_d       = next_pc;
                            if (!stall) begin
                                to_dec_d = 1'b1;
                                state_d  = ST_REQ;
                            end else begin
                                state_d  = ST_HOLD;
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (!stall) begin
                            to_dec_d = 1'b1;
                            state_d  = ST_REQ;
                        end
                    end
                    default: state_d = ST_REQ;
                endcase
            end
        end
    end

    assign fetch_if.icache_req     = req_q;
    assign fetch_if.icache_addr    = addr_q;
    assign fetch_if.to_dec         = to_dec_q;
    assign fetch_if.to_dec_pc      = dec_pc_q;
    assign fetch_if.to_dec_inst    = dec_inst_q;
    assign fetch_if.to_dec_pred_pc = pred_q;

endmodule

// File: doc/instruction_fetcher.md
Name: instruction_fetcher

Overview:
- Front-end block that produces the instruction stream consumed by the decoder's from_if / pc / instruction inputs.
- Owns the architectural fetch PC and issues one request at a time to the instruction cache.
- Delivers each fetched word to the decoder as a one-cycle valid pulse, and holds it while the back end is stalled.
- Performs static next-PC prediction: JAL is taken, everything else is PC+4. It redirects on the ROB clear.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- XLEN, 32, width of PC and instruction datapaths.

Ports:
- clk_in  input  1  system clock, rising edge.
- rst_in  input  1  asynchronous, active-low reset.
- rdy_in  input  1  global enable; when 0, all state and outputs hold.
- clear  input  1  misprediction flush from the ROB; highest priority after reset.
- clear_pc  input  XLEN  correct restart PC, valid with clear.
- stall  input  1  back end (RS/LSB/ROB) cannot accept an instruction this cycle.
- icache_req  output  1  fetch request, level-held until answered.
- icache_addr  output  XLEN  fetch address, bits [1:0] always 0.
- icache_valid  input  1  one-cycle pulse, icache_inst valid.
- icache_inst  input  XLEN  fetched instruction word.
- to_dec  output  1  one-cycle pulse: to_dec_pc and to_dec_inst are valid (drives decoder from_if).
- to_dec_pc  output  XLEN  PC of delivered instruction.
- to_dec_inst  output  XLEN  delivered instruction word.
- to_dec_pred_pc  output  XLEN  predicted next PC, forwarded to the ROB for branch resolution.

Behaviour:
- All outputs are registered.
- Reset (rst_in=0, asynchronous):
  - pc=RESET_PC, state=REQ.
  - icache_req=0, icache_addr=0, to_dec=0, to_dec_pc=0, to_dec_inst=0, to_dec_pred_pc=0.
- rdy_in=0: no register changes. The clear, stall and icache_valid inputs are ignored that cycle.
- Default each enabled cycle: to_dec<=0, unless explicitly set below.
- State REQ:
  - If !stall: icache_req<=1, icache_addr<=pc, go to WAIT.
  - Otherwise remain in REQ.
- State WAIT:
  - icache_req stays 1 until icache_valid.
  - On icache_valid:
    - icache_req<=0.
    - next_pc = pc+sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}) if inst[6:0]==7'b1101111; else next_pc = pc+4. Arithmetic is modulo 2^32.
    - to_dec_pc<=pc, to_dec_inst<=inst, to_dec_pred_pc<=next_pc, pc<=next_pc.
    - If !stall: to_dec<=1, go to REQ.
    - If stall: go to HOLD; the word is captured, to_dec stays 0.
  - icache_valid outside WAIT is ignored.
- State HOLD:
  - When !stall: to_dec<=1, go to REQ.
  - The captured outputs are unchanged while in HOLD.
- Throughput: one instruction per (icache latency + 2) cycles with no stall. The next request issues the cycle after delivery.
- clear (any state, including the cycle icache_valid arrives):
  - pc<={clear_pc[31:2],2'b00}.
  - icache_req<=0, to_dec<=0, state<=REQ.
  - Any held or arriving word is discarded.
  - The icache must abort an outstanding access when icache_req drops.
- Branches and JALR are predicted not-taken (pred_pc = pc+4). The ROB corrects them via clear.
- Reset asserted mid-WAIT drops icache_req immediately (asynchronous).

Decomposition:
- Shared package (with the decoder's opcode set): opcode constants OPC_JAL=7'b1101111, OPC_JALR, OPC_BRANCH, plus XLEN and RESET_PC defaults.
- Sub-module next_pc_gen (combinational):
  - Inputs: pc, inst. Output: next_pc.
  - Holds the J-immediate extraction and the adder, so it can be unit-tested in isolation.

Test Plan:
- Reset release, icache latency 2, non-JAL words at 0x0/0x4/0x8 -> icache_addr 0x0, 0x4, 0x8 in order; to_dec pulses carry pc 0x0/0x4/0x8, pred_pc +4 each; 4-cycle spacing.
- Fetch inst 0x0100006F (JAL +16) at pc 0x20 -> to_dec_pred_pc=0x30, next icache_addr=0x30. Fetch inst 0xFFDFF06F (JAL -4) at pc 0x40 -> next icache_addr=0x3C.
- stall held high in the cycle icache_valid arrives, released 3 cycles later -> to_dec stays 0 during stall, then exactly one pulse with the captured pc/inst; no new icache_req until after delivery.
- clear with clear_pc=0x1003 in the same cycle as icache_valid -> no to_dec pulse, icache_req drops, next icache_addr=0x1000.
- rdy_in low for 5 cycles during WAIT with icache_valid=0 -> all outputs frozen; operation resumes identically when rdy_in returns to 1.
- rst_in pulled low mid-WAIT -> icache_req=0 and to_dec=0 immediately (asynchronously); after release, first icache_addr=RESET_PC.
